uart_tx_fifo_param: RTL and testbench
=====================================

// Module: uart_tx_fifo_param
// PURPOSE
//   Parametrised UART transmitter, successor to the fixed 8-bit, one-clock-per-bit TX.
//   Adds configurable data width, a baud divider, selectable 1/2 stop bits, an input FIFO
//   with valid/ready handshake, and back-to-back frames with no idle gap.
//   Sits between the host-side parallel write port and the serial TX pin.
// PARAMETERS
//   DATA_W       8  data bits per frame, legal 5..9, sent LSB first
//   CLKS_PER_BIT 4  clk cycles per serial bit period, >=1
//   FIFO_DEPTH   4  input FIFO entries, power of 2, >=2
// PORTS
//   clk         in   1                        system clock, all state on rising edge
//   reset       in   1                        asynchronous, active-low reset
//   P_DATA      in   DATA_W                   parallel word to transmit
//   DATA_VALID  in   1                        P_DATA valid; accepted when DATA_READY=1
//   DATA_READY  out  1                        FIFO not full (= !full, combinational)
//   PAR_EN      in   1                        1: append parity bit (sampled at dequeue)
//   PAR_TYP     in   1                        parity select (sampled at dequeue)
//   STOP2       in   1                        1: two stop bits, 0: one (sampled at dequeue)
//   TX_OUT      out  1                        serial line, idles high, registered
//   Busy        out  1                        1 while state != IDLE, registered
//   FIFO_LEVEL  out  $clog2(FIFO_DEPTH+1)     entries currently held
//   FRAME_DONE  out  1                        1-cycle pulse in final cycle of last stop bit
// BEHAVIOUR
//   Reset (async assert): TX_OUT=1, Busy=0, FRAME_DONE=0, FIFO_LEVEL=0, FIFO pointers=0,
//     state=IDLE, bit/baud counters=0. Mid-frame reset aborts the frame; queued words dropped.
//   FIFO: write on edge where DATA_VALID && DATA_READY. Full -> DATA_READY=0, word held
//     by source. Simultaneous write+dequeue: level unchanged. Pointers wrap mod FIFO_DEPTH.
//   States IDLE, START, DATA, PARITY, STOP. Each state other than IDLE holds one bit
//     period = CLKS_PER_BIT cycles via baud counter 0..CLKS_PER_BIT-1.
//   IDLE: TX_OUT=1. If FIFO non-empty -> dequeue on this edge, load shift reg, latch
//     PAR_EN/PAR_TYP/STOP2, compute parity, next state START. A word written at edge N
//     is dequeued at edge N+1 earliest.
//   Parity: PAR_TYP=0 -> ~^data; PAR_TYP=1 -> ^data (over DATA_W bits).
//   START: TX_OUT=0 -> DATA with bit index 0.
//   DATA: TX_OUT=data[idx]; idx increments at end of each bit period; after idx=DATA_W-1
//     -> PARITY if latched PAR_EN else STOP.
//   PARITY: TX_OUT=latched parity -> STOP.
//   STOP: TX_OUT=1 for 1 or 2 bit periods (latched STOP2). At end: FRAME_DONE=1 that
//     cycle; if FIFO non-empty dequeue and go straight to START (no IDLE cycle), else IDLE.
//   TX_OUT and state change on the same edge; frame length in cycles =
//     (1 + DATA_W + PAR_EN + 1 + STOP2) * CLKS_PER_BIT.
//   Config inputs changing mid-frame do not affect the frame in progress.
//   Busy=1 from edge entering START until edge returning to IDLE; stays 1 across
//     back-to-back frames.
// TESTING  (DATA_W=8, CLKS_PER_BIT=4, FIFO_DEPTH=4)
//   1 Assert reset -> TX_OUT=1, Busy=0, FIFO_LEVEL=0, DATA_READY=1, FRAME_DONE=0.
//   2 Write 0xA5, PAR_EN=1, PAR_TYP=0, STOP2=0 -> line 0,1,0,1,0,0,1,0,1,1(par),1(stop),
//     each bit 4 cycles, 44-cycle frame, FRAME_DONE in cycle 44, then Busy=0.
//   3 While busy, write 4 words -> FIFO_LEVEL=4, DATA_READY=0; 5th word held by
//     DATA_VALID accepted on the edge after next dequeue, level stays 4.
//   4 Queue 0x00 and 0xFF, PAR_EN=0, STOP2=1 -> two 44-cycle frames, START of 2nd
//     immediately after last STOP cycle of 1st, Busy never drops between them.
//   5 Reset asserted mid-DATA with 2 queued -> TX_OUT=1 and FIFO_LEVEL=0 immediately;
//     after release line stays 1, Busy=0, no frame sent.
//   6 Toggle PAR_EN 1->0 and STOP2 0->1 during DATA -> current frame still sends parity,
//     one stop bit; next frame uses new settings.

Source files
------------

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter with input FIFO, baud divider, optional parity and 1/2 stop bits.
// Frames run back to back while the FIFO holds data.
module uart_tx_fifo_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_W-1:0]                 P_DATA,
  input  logic                              DATA_VALID,
  output logic                              DATA_READY,
  input  logic                              PAR_EN,
  input  logic                              PAR_TYP,
  input  logic                              STOP2,
  output logic                              TX_OUT,
  output logic                              Busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   FIFO_LEVEL,
  output logic                              FRAME_DONE
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int IW = $clog2(DATA_W);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic              wr;
  logic              deq;
  logic              full;
  logic [DATA_W-1:0] head;

  logic [2:0]        state;
  logic [CW-1:0]     baud;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] shreg;
  logic              par_en_q;
  logic              parity_q;
  logic              stop2_q;
  logic              stop_idx;
  logic              bit_end;

  assign full       = (level == LW'(FIFO_DEPTH));
  assign DATA_READY = !full;
  assign wr         = DATA_VALID && !full;
  assign head       = mem[rd_ptr];
  assign FIFO_LEVEL = level;
  assign bit_end    = (baud == CW'(CLKS_PER_BIT-1));
  assign FRAME_DONE = (state == S_STOP) && bit_end && (stop_idx == stop2_q);
  // A word is only taken from idle or at the very end of a frame
  assign deq        = (level != '0) && ((state == S_IDLE) || FRAME_DONE);

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= P_DATA;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      unique case ({wr, deq})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      TX_OUT   <= 1'b1;
      Busy     <= 1'b0;
      baud     <= '0;
      idx      <= '0;
      shreg    <= '0;
      par_en_q <= 1'b0;
      parity_q <= 1'b0;
      stop2_q  <= 1'b0;
      stop_idx <= 1'b0;
    end else begin
      baud <= (state == S_IDLE || bit_end || deq) ? '0 : baud + CW'(1);
      if (deq) begin
        state    <= S_START;
        TX_OUT   <= 1'b0;
        Busy     <= 1'b1;
        shreg    <= head;
        par_en_q <= PAR_EN;
        stop2_q  <= STOP2;
        parity_q <= PAR_TYP ? ^head : ~^head;
        stop_idx <= 1'b0;
      end else if (bit_end) begin
        unique case (1'b1)
          state == S_START: begin
            state  <= S_DATA;
            idx    <= '0;
            TX_OUT <= shreg[0];
          end
          state == S_DATA: begin
            if (idx == IW'(DATA_W-1)) begin
              state  <= par_en_q ? S_PAR : S_STOP;
              TX_OUT <= par_en_q ? parity_q : 1'b1;
            end else begin
              idx    <= idx + IW'(1);
              shreg  <= shreg >> 1;
              TX_OUT <= shreg[1];
            end
          end
          state == S_PAR: begin
            state  <= S_STOP;
            TX_OUT <= 1'b1;
          end
          state == S_STOP: begin
            if (stop2_q && !stop_idx) begin
              stop_idx <= 1'b1;
            end else begin
              state  <= S_IDLE;
              Busy   <= 1'b0;
              TX_OUT <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Directed + random bench for uart_tx_fifo_param against a frame-level
// reference model (word queue and per-frame bit list).
module tb_uart_tx_fifo_param;

  localparam int DW    = 8;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID;
  logic          DATA_READY;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          STOP2;
  logic          TX_OUT;
  logic          Busy;
  logic [2:0]    FIFO_LEVEL;
  logic          FRAME_DONE;

  int vectors = 0;
  int errs    = 0;

  int q[$];
  bit in_frame = 0;
  int pos = 0;
  int len = 0;
  bit bits [0:15];

  uart_tx_fifo_param #(
    .DATA_W(DW), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .P_DATA(P_DATA),
    .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .TX_OUT(TX_OUT), .Busy(Busy), .FIFO_LEVEL(FIFO_LEVEL),
    .FRAME_DONE(FRAME_DONE)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(int w, bit pe, bit pt, bit s2);
    int nb;
    int ones;
    ones = 0;
    bits[0] = 1'b0;
    nb = 1;
    for (int i = 0; i < DW; i++) begin
      bits[nb] = w[i];
      ones += w[i];
      nb++;
    end
    if (pe) begin
      bits[nb] = pt ? ones[0] : !ones[0];
      nb++;
    end
    bits[nb] = 1'b1;
    nb++;
    if (s2) begin
      bits[nb] = 1'b1;
      nb++;
    end
    len = nb * CPB;
    pos = 0;
    in_frame = 1;
  endtask

  task automatic tick(output bit acc);
    bit pe, pt, s2, deq;
    int w;
    acc = 0;
    if (!reset) begin
      @(posedge clk);
      #1;
      chk("rst_tx", TX_OUT, 1);
      chk("rst_level", FIFO_LEVEL, 0);
      chk("rst_busy", Busy, 0);
      return;
    end
    chk("ready", DATA_READY, q.size() < DEPTH);
    pe  = PAR_EN;
    pt  = PAR_TYP;
    s2  = STOP2;
    w   = int'(P_DATA);
    acc = DATA_VALID && (q.size() < DEPTH);
    deq = (q.size() > 0) && (!in_frame || pos == len - 1);
    @(posedge clk);
    #1;
    if (in_frame) pos++;
    if (in_frame && pos == len) in_frame = 0;
    if (deq) start_frame(q.pop_front(), pe, pt, s2);
    if (acc) q.push_back(w);
    chk("tx", TX_OUT, in_frame ? bits[pos / CPB] : 1'b1);
    chk("busy", Busy, in_frame);
    chk("frame_done", FRAME_DONE, in_frame && pos == len - 1);
    chk("level", FIFO_LEVEL, q.size());
  endtask

  task automatic run(int n);
    bit a;
    for (int k = 0; k < n; k++) tick(a);
  endtask

  task automatic push(int w);
    bit a;
    a = 0;
    DATA_VALID = 1'b1;
    P_DATA = DW'(w);
    for (int k = 0; k < 400 && !a; k++) tick(a);
    vectors++;
    assert (a) else begin
      errs++;
      $error("FAIL push_timeout observed=%0d expected=1", a);
    end
    DATA_VALID = 1'b0;
  endtask

  task automatic drain();
    bit a;
    int k;
    k = 0;
    while ((in_frame || q.size() > 0) && k < 3000) begin
      tick(a);
      k++;
    end
    vectors++;
    assert (k < 3000) else begin
      errs++;
      $error("FAIL drain_timeout observed=%0d expected<3000", k);
    end
    run(2);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    chk("areset_tx", TX_OUT, 1);
    chk("areset_level", FIFO_LEVEL, 0);
    chk("areset_busy", Busy, 0);
    chk("areset_ready", DATA_READY, 1);
    chk("areset_done", FRAME_DONE, 0);
    q.delete();
    in_frame = 0;
    run(3);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    P_DATA = '0;
    DATA_VALID = 1'b0;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    STOP2 = 1'b0;
    #2;
    apply_reset();
    run(3);

    // single parity frame
    PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0;
    push(8'hA5);
    drain();

    // fill the FIFO behind a running frame, then hold a fifth word
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    push(8'h55);
    chk("full_level", FIFO_LEVEL, 4);
    chk("full_ready", DATA_READY, 0);
    push(8'h66);
    drain();

    // back-to-back frames, no parity, two stop bits
    PAR_EN = 1'b0; STOP2 = 1'b1;
    push(8'h00);
    push(8'hFF);
    drain();

    // reset in the middle of a data bit with words queued
    PAR_EN = 1'b1; STOP2 = 1'b0;
    push(8'h5A);
    push(8'h81);
    push(8'h7E);
    run(14);
    apply_reset();
    run(60);

    // config change during data does not touch the current frame
    PAR_EN = 1'b1; PAR_TYP = 1'b1; STOP2 = 1'b0;
    push(8'h3C);
    push(8'hC3);
    run(14);
    PAR_EN = 1'b0; STOP2 = 1'b1;
    drain();

    // random words, configs and gaps
    for (int i = 0; i < 30; i++) begin
      PAR_EN  = 1'($urandom % 2);
      PAR_TYP = 1'($urandom % 2);
      STOP2   = 1'($urandom % 2);
      push(int'($urandom_range(0, 255)));
      if ($urandom % 3 == 0) run(int'($urandom_range(0, 50)));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
